// File: rtl/instr_fetch_pkg.sv
// Shared MIPS pipeline types: PC/instruction widths and fetch FSM states.
// Imported by the fetch stage, its cache array and the refill interface.
package mips_pkg;
  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/instr_fetch_if.sv
// Refill handshake between the fetch stage and instruction memory.
// master: mem_req/mem_addr out, mem_valid/mem_data in; slave: the reverse.
interface instr_fetch_if import mips_pkg::*; ();
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_valid;
  logic [INSTR_W-1:0] mem_data;

  modport master (
    output mem_req, mem_addr,
    input  mem_valid, mem_data
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_valid, mem_data
  );
endinterface

// File: rtl/icache_array.sv
// Direct-mapped I-cache storage: async read, one sync write, valid clear on rst.
// Ports: clk, rst, i_rd_idx -> o_rd_{valid,tag,data}; i_wr_{en,idx,tag,data}.
module icache_array import mips_pkg::*; #(
  parameter  int INDEX_BITS = 4,
  localparam int TAG_W      = PC_W - INDEX_BITS,
  localparam int LINES      = 1 << INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  output logic                  o_rd_valid,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic [INSTR_W-1:0]    o_rd_data,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [INSTR_W-1:0]    i_wr_data
);
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [INSTR_W-1:0] r_data [LINES];

  always_ff @(posedge clk) begin
    if (rst)
      r_valid <= '0;
    else if (i_wr_en)
      r_valid[i_wr_idx] <= 1'b1;
  end

  // Tag/data need no reset; a write during reset is dropped
  // so an aborted refill never leaves stale payload behind.
  always_ff @(posedge clk) begin
    if (i_wr_en && !rst) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];
endmodule

// File: rtl/instr_fetch.sv
// IF stage: PC, I-cache lookup, miss refill FSM, branch redirect, D-miss freeze.
// Ports: clk, rst, data_hit, branch_*, npc/instr/instruction_hit, mem (refill).
// Optional IFETCH_PERF_EN adds miss_count/fetch_count saturating counters.
module instr_fetch import mips_pkg::*; #(
  parameter int              INDEX_BITS = 4,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_hit,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    npc,
  output logic [INSTR_W-1:0] instr,
  output logic               instruction_hit,
  instr_fetch_if.master      mem
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        miss_count,
  output logic [31:0]        fetch_count
`endif
);
  localparam int TAG_W = PC_W - INDEX_BITS;

  fetch_state_e    r_state, w_state_n;
  logic [PC_W-1:0] r_pc, w_pc_n;
  logic            r_mem_req, w_req_n;
  logic [PC_W-1:0] r_mem_addr, w_addr_n;
  logic            r_pend, w_pend_n;
  logic [PC_W-1:0] r_redir_pc, w_redir_n;

  logic               w_valid;
  logic [TAG_W-1:0]   w_tag;
  logic [INSTR_W-1:0] w_data;
  logic               w_hit;
  logic               w_wr_en;

  icache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (r_pc[INDEX_BITS-1:0]),
    .o_rd_valid (w_valid),
    .o_rd_tag   (w_tag),
    .o_rd_data  (w_data),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (r_mem_addr[INDEX_BITS-1:0]),
    .i_wr_tag   (r_mem_addr[PC_W-1:INDEX_BITS]),
    .i_wr_data  (mem.mem_data)
  );

  assign w_hit = w_valid && (w_tag == r_pc[PC_W-1:INDEX_BITS])
              && (r_state == IDLE);

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_req_n   = r_mem_req;
    w_addr_n  = r_mem_addr;
    w_pend_n  = r_pend;
    w_redir_n = r_redir_pc;
    w_wr_en   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (branch_taken) begin
          w_pc_n = branch_target;
        end else if (w_hit) begin
          if (data_hit)
            w_pc_n = r_pc + 30'd1;
        end else begin
          w_state_n = REQ;
          w_req_n   = 1'b1;
          w_addr_n  = r_pc;
        end
      end
      REQ: begin
        if (mem.mem_valid) begin
          w_wr_en   = 1'b1;
          w_state_n = IDLE;
          w_req_n   = 1'b0;
          w_pend_n  = 1'b0;
          // A same-cycle branch is newer than any latched one.
          if (branch_taken)
            w_pc_n = branch_target;
          else if (r_pend)
            w_pc_n = r_redir_pc;
        end else if (branch_taken) begin
          w_pend_n  = 1'b1;
          w_redir_n = branch_target;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_pend     <= 1'b0;
      r_redir_pc <= '0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_mem_req  <= w_req_n;
      r_mem_addr <= w_addr_n;
      r_pend     <= w_pend_n;
      r_redir_pc <= w_redir_n;
    end
  end

  assign npc             = r_pc + 30'd1;
  assign instr           = w_data;
  assign instruction_hit = w_hit;
  assign mem.mem_req     = r_mem_req;
  assign mem.mem_addr    = r_mem_addr;

`ifdef IFETCH_PERF_EN
  logic [31:0] r_miss_cnt, r_fetch_cnt;
  logic        w_miss_ev, w_fetch_ev;

  assign w_miss_ev  = (r_state == IDLE) && (w_state_n == REQ);
  assign w_fetch_ev = w_hit && data_hit && !branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss_cnt  <= '0;
      r_fetch_cnt <= '0;
    end else begin
      if (w_miss_ev && r_miss_cnt != 32'hFFFF_FFFF)
        r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_fetch_ev && r_fetch_cnt != 32'hFFFF_FFFF)
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign miss_count  = r_miss_cnt;
  assign fetch_count = r_fetch_cnt;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (INDEX_BITS=4, RESET_PC=0).
// Drives the refill slave side with a fixed 3-cycle memory latency.
module tb_instr_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_hit = 1'b1;
  logic        branch_taken = 1'b0;
  logic [29:0] branch_target = '0;
  logic [29:0] npc;
  logic [31:0] instr;
  logic        instruction_hit;

  instr_fetch_if mem_if ();

`ifdef IFETCH_PERF_EN
  logic [31:0] miss_count, fetch_count;
`endif

  instr_fetch #(.INDEX_BITS(4), .RESET_PC(30'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_hit        (data_hit),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .npc             (npc),
    .instr           (instr),
    .instruction_hit (instruction_hit),
    .mem             (mem_if.master)
`ifdef IFETCH_PERF_EN
    ,
    .miss_count      (miss_count),
    .fetch_count     (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic redirect(input logic [29:0] t);
    branch_taken  = 1'b1;
    branch_target = t;
    step();
    branch_taken  = 1'b0;
  endtask

  // Wait (bounded) for a request, answer it 3 cycles after it rose.
  task automatic fill(input logic [29:0] a);
    int n = 0;
    while (mem_if.mem_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("fill_req", {31'b0, mem_if.mem_req}, 32'd1);
    chk("fill_addr", {2'b0, mem_if.mem_addr}, {2'b0, a});
    step();
    step();
    mem_if.mem_valid = 1'b1;
    mem_if.mem_data  = mem_word(a);
    step();
    mem_if.mem_valid = 1'b0;
  endtask

  task automatic fill_hit(input logic [29:0] a);
    fill(a);
    chk("refill_hit", {31'b0, instruction_hit}, 32'd1);
    chk("refill_instr", instr, mem_word(a));
    chk("refill_npc", {2'b0, npc}, {2'b0, a} + 32'd1);
  endtask

  initial begin
    mem_if.mem_valid = 1'b0;
    mem_if.mem_data  = '0;

    step();
    step();
    chk("rst_hit", {31'b0, instruction_hit}, 32'd0);
    chk("rst_npc", {2'b0, npc}, 32'd1);
    chk("rst_req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("rst_addr", {2'b0, mem_if.mem_addr}, 32'd0);
    rst = 1'b0;

    fill_hit(30'd0);
    step();
    chk("hit_pulse", {31'b0, instruction_hit}, 32'd0);
    fill_hit(30'd1);
    step();
    fill_hit(30'd2);
    step();
    fill_hit(30'd3);

    step();
    redirect(30'd0);
    chk("redir_noreq", {31'b0, mem_if.mem_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("loop_hit", {31'b0, instruction_hit}, 32'd1);
      chk("loop_npc", {2'b0, npc}, i + 1);
      chk("loop_instr", instr, mem_word(30'(i)));
      chk("loop_noreq", {31'b0, mem_if.mem_req}, 32'd0);
      step();
    end

    redirect(30'h10);
`ifdef IFETCH_PERF_EN
    chk("miss_count", miss_count, 32'd4);
    chk("fetch_count", fetch_count, 32'd8);
`endif
    chk("conflict_miss", {31'b0, instruction_hit}, 32'd0);
    chk("conflict_npc", {2'b0, npc}, 32'h11);
    fill_hit(30'h10);
    redirect(30'd0);
    chk("tag_replaced", {31'b0, instruction_hit}, 32'd0);
    fill_hit(30'd0);

    redirect(30'd5);
    chk("pc5_miss", {31'b0, instruction_hit}, 32'd0);
    step();
    chk("pc5_req", {31'b0, mem_if.mem_req}, 32'd1);
    chk("pc5_addr", {2'b0, mem_if.mem_addr}, 32'd5);
    redirect(30'h100);
    chk("req_hold", {31'b0, mem_if.mem_req}, 32'd1);
    step();
    mem_if.mem_valid = 1'b1;
    mem_if.mem_data  = mem_word(30'd5);
    step();
    mem_if.mem_valid = 1'b0;
    chk("redir_npc", {2'b0, npc}, 32'h101);
    chk("redir_hit", {31'b0, instruction_hit}, 32'd0);
    chk("redir_req_low", {31'b0, mem_if.mem_req}, 32'd0);
    fill_hit(30'h100);
    redirect(30'd5);
    chk("line5_hit", {31'b0, instruction_hit}, 32'd1);
    chk("line5_instr", instr, mem_word(30'd5));

    step();
    fill_hit(30'd6);
    step();
    fill_hit(30'd7);
    data_hit = 1'b0;
    repeat (5) begin
      step();
      chk("stall_npc", {2'b0, npc}, 32'd8);
      chk("stall_hit", {31'b0, instruction_hit}, 32'd1);
      chk("stall_instr", instr, mem_word(30'd7));
    end
    data_hit = 1'b1;
    step();
    chk("resume_npc", {2'b0, npc}, 32'd9);
    chk("resume_miss", {31'b0, instruction_hit}, 32'd0);
    step();
    chk("pc8_req", {31'b0, mem_if.mem_req}, 32'd1);
    chk("pc8_addr", {2'b0, mem_if.mem_addr}, 32'd8);

    rst = 1'b1;
    step();
    chk("abort_req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("abort_npc", {2'b0, npc}, 32'd1);
    chk("abort_hit", {31'b0, instruction_hit}, 32'd0);
    mem_if.mem_valid = 1'b1;
    mem_if.mem_data  = mem_word(30'd8);
    step();
    mem_if.mem_valid = 1'b0;
    rst = 1'b0;

    mem_if.mem_valid = 1'b1;
    redirect(30'd8);
    mem_if.mem_valid = 1'b0;
    chk("line8_invalid", {31'b0, instruction_hit}, 32'd0);
    chk("idle_valid_ign", {31'b0, mem_if.mem_req}, 32'd0);
    fill_hit(30'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the cached MIPS pipeline; the producer side of the IF/ID register.
- Holds the PC (30-bit word address) and looks it up in a small direct-mapped instruction cache.
- Presents `npc`, `instr` and `instruction_hit` to IF/ID.
- On a miss, runs a refill handshake with instruction memory.
- Redirects on taken branches and freezes while the data cache misses (`data_hit` low).

## Interface
- `INDEX_BITS`, 4: cache index width; 2^INDEX_BITS one-word lines; tag width = 30 − INDEX_BITS.
- `RESET_PC`, 30'h0: word address loaded into PC on reset.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_hit`  in  1  D-cache hit; low = whole pipeline stalled.
- `branch_taken`  in  1  redirect request.
- `branch_target`  in  30  redirect word address.
- `npc`  out  30  PC + 1 (mod 2^30) of the instruction presented.
- `instr`  out  32  cached instruction at PC; don't-care when `instruction_hit`=0.
- `instruction_hit`  out  1  `instr` valid this cycle.
- `mem_req`  out  1  refill request, registered.
- `mem_addr`  out  30  refill word address, registered, stable while `mem_req`=1.
- `mem_valid`  in  1  refill data valid, single-cycle pulse.
- `mem_data`  in  32  refill word.

## Operation
- Lookup is combinational from registered arrays: index = `pc[INDEX_BITS-1:0]`, tag = `pc[29:INDEX_BITS]`.
- `instruction_hit` = valid[index] && tag match && state==IDLE.
- FSM states: IDLE, REQ.
- IDLE:
  - hit && `data_hit` && !`branch_taken`: pc ← pc+1 (wraps 30'h3FFFFFFF→0).
  - `branch_taken` (any `data_hit`): pc ← `branch_target`; the instruction at the old PC is not consumed. Redirect is idempotent, so a held request re-targets the same address.
  - miss && !`branch_taken`: mem_req ← 1, mem_addr ← pc, go to REQ.
- REQ:
  - `mem_req` stays high.
  - `branch_taken`: latch redir_pend ← 1, redir_pc ← `branch_target`. The last request wins.
  - `mem_valid`: write line[mem_addr index] = {valid=1, tag, mem_data}; mem_req ← 0; go to IDLE. If redir_pend, pc ← redir_pc and clear redir_pend; otherwise pc is unchanged and the next cycle hits.
  - `branch_taken` and `mem_valid` in the same cycle: the fill completes and pc ← `branch_target` directly.
- `mem_valid` in IDLE is ignored.
- Refill does not wait for `data_hit`; a D-miss and an I-miss may overlap.
- Reset values:
  - pc = RESET_PC; all valid bits = 0; state = IDLE.
  - mem_req = 0; mem_addr = 0; redir_pend = 0.
  - Therefore `instruction_hit` = 0 and `npc` = RESET_PC+1.
- Reset mid-refill: abort; `mem_req` low the next cycle; the line is not written.

## Timing
- Hit: `instr`/`npc` valid in the same cycle as pc; throughput one instruction per cycle while `data_hit`=1.
- Miss: `mem_req` rises the cycle after the miss is seen; `mem_valid` k ≥ 1 cycles later; `instruction_hit` returns the cycle after `mem_valid`. Miss penalty = k + 2 cycles.
- Branch: new PC is looked up the cycle after `branch_taken` is sampled.
- `data_hit`=0: pc frozen; outputs stable except during refill completion.

## Configuration
- `IFETCH_PERF_EN`:
  - Defined: adds outputs `miss_count` (32) and `fetch_count` (32).
    - `miss_count` increments on each IDLE→REQ transition.
    - `fetch_count` increments on each cycle with `instruction_hit` && `data_hit` && !`branch_taken`.
    - Both cleared by `rst` and saturate at 32'hFFFFFFFF.
  - Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `mips_pkg`: PC width (30), instruction width (32), FSM state enum {IDLE, REQ}.
- Sub-module `icache_array`: holds valid/tag/data.
  - Asynchronous read port.
  - Single synchronous write port.
  - Synchronous clear of valid bits on `rst`.
- `instr_fetch` holds PC, FSM, redirect latch and counters.

## Test plan
- Reset, then `mem_valid` at 3 cycles after each `mem_req`, `data_hit`=1: fetch 0,1,2 → each misses once.
  - `mem_addr` = 0,1,2; `instruction_hit` pulses 1 cycle after each `mem_valid`.
  - After refill, `npc` = 1,2,3.
- Loop 0..3 twice: second pass hits every cycle, no `mem_req`. With the macro defined, `miss_count`=4 and `fetch_count`=8.
- Line conflict with INDEX_BITS=4: fetch 0x10 after 0x00 → miss, tag replaced; refetch 0x00 → miss again.
- `branch_taken` with target 0x100 during REQ for pc=5: fill of line 5 completes, then pc=0x100 and `mem_addr`=0x100 on the next miss.
- `data_hit`=0 for 5 cycles on a hit at pc=7: `npc` stays 8 and `instr` stays stable; pc advances only after `data_hit` returns.
- `rst` asserted mid-REQ: `mem_req`=0 next cycle; pc=RESET_PC; the later `mem_valid` is ignored and the line stays invalid.
